// File: rtl/fetch_sequencer.sv
// Instruction-cycle sequencer sitting in front of the program counter:
// fetch -> IR latch -> execute wait -> PC update, with halt/resume and ack timeout.
module fetch_sequencer #(
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 15
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              mem_ack,
    input  logic              exec_done,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              halt_req,
    output logic              pc_load,
    output logic              pc_inc,
    output logic [ADDR_W-1:0] pc_target,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              ir_load,
    output logic              halted,
    output logic              err,
    output logic [2:0]        state
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_LATCH  = 3'd2,
        S_EXEC   = 3'd3,
        S_UPDATE = 3'd4,
        S_HALT   = 3'd5,
        S_ERROR  = 3'd6
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [ADDR_W-1:0] target_q;
    logic [CW-1:0]     wait_cnt_q;
    logic              halt_pend_q;
    logic              taken_q;
    logic              fetch_first;

    assign fetch_first = (state_q == S_FETCH) && (wait_cnt_q == '0);

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            mem_addr_q  <= '0;
            target_q    <= '0;
            wait_cnt_q  <= '0;
            halt_pend_q <= 1'b0;
            taken_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        state_q     <= S_FETCH;
                        mem_addr_q  <= pc_in;
                        wait_cnt_q  <= '0;
                        halt_pend_q <= 1'b0;
                    end
                end
                S_FETCH: begin
                    halt_pend_q <= halt_pend_q | halt_req;
                    // The counter steps on the UPDATE edge, so the fresh PC is sampled here
                    if (fetch_first) begin
                        mem_addr_q <= pc_in;
                    end
                    if (mem_ack) begin
                        state_q <= S_LATCH;
                    end else if (wait_cnt_q == CW'(TIMEOUT - 1)) begin
                        state_q <= S_ERROR;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + CW'(1);
                    end
                end
                S_LATCH: begin
                    halt_pend_q <= halt_pend_q | halt_req;
                    state_q     <= S_EXEC;
                end
                S_EXEC: begin
                    halt_pend_q <= halt_pend_q | halt_req;
                    if (exec_done) begin
                        taken_q  <= branch_taken;
                        target_q <= branch_target;
                        state_q  <= S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    halt_pend_q <= halt_pend_q | halt_req;
                    if (halt_pend_q || halt_req) begin
                        state_q <= S_HALT;
                    end else begin
                        state_q    <= S_FETCH;
                        mem_addr_q <= pc_in;
                        wait_cnt_q <= '0;
                    end
                end
                S_ERROR: state_q <= S_ERROR;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign mem_req   = (state_q == S_FETCH);
    assign mem_addr  = fetch_first ? pc_in : mem_addr_q;
    assign ir_load   = (state_q == S_LATCH);
    assign pc_load   = (state_q == S_UPDATE) && taken_q;
    assign pc_inc    = (state_q == S_UPDATE) && !taken_q;
    assign pc_target = pc_load ? target_q : '0;
    assign halted    = (state_q == S_HALT);
    assign err       = (state_q == S_ERROR);
    assign state     = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a small 4-bit program-counter model
// feeding pc_in from the sequencer's load/inc strobes.
module tb_fetch_sequencer;

    logic       clock = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] pc_in;
    logic       mem_ack;
    logic       exec_done;
    logic       branch_taken;
    logic [3:0] branch_target;
    logic       halt_req;
    logic       pc_load;
    logic       pc_inc;
    logic [3:0] pc_target;
    logic       mem_req;
    logic [3:0] mem_addr;
    logic       ir_load;
    logic       halted;
    logic       err;
    logic [2:0] state;

    logic       set_req;
    logic [3:0] set_val;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    fetch_sequencer #(.ADDR_W(4), .TIMEOUT(15)) dut (
        .clock         (clock),
        .rst           (rst),
        .start         (start),
        .pc_in         (pc_in),
        .mem_ack       (mem_ack),
        .exec_done     (exec_done),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .halt_req      (halt_req),
        .pc_load       (pc_load),
        .pc_inc        (pc_inc),
        .pc_target     (pc_target),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .ir_load       (ir_load),
        .halted        (halted),
        .err           (err),
        .state         (state)
    );

    // Program counter model: preset, load or increment with 4-bit wrap
    always @(posedge clock) begin
        if (set_req) pc_in <= set_val;
        else if (pc_load) pc_in <= pc_target;
        else if (pc_inc) pc_in <= pc_in + 4'd1;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mem_ack = 1'b0; exec_done = 1'b0;
        branch_taken = 1'b0; branch_target = 4'h0; halt_req = 1'b0;
        set_req = 1'b1; set_val = 4'h3;
        tick();
        set_req = 1'b0;
        tick();
        chk("rst_state", 8'(state), 8'd0);
        chk("rst_mem_req", 8'(mem_req), 8'd0);
        chk("rst_err", 8'(err), 8'd0);
        chk("rst_halted", 8'(halted), 8'd0);
        rst = 1'b0;
        tick(); tick();
        chk("idle_hold", 8'(state), 8'd0);

        // sequential fetch at 3
        start = 1'b1;
        tick();
        chk("f2_state", 8'(state), 8'd1);
        chk("f2_req", 8'(mem_req), 8'd1);
        chk("f2_addr", 8'(mem_addr), 8'h3);
        start = 1'b0; mem_ack = 1'b1;
        tick();
        chk("f2_latch", 8'(state), 8'd2);
        chk("f2_irload", 8'(ir_load), 8'd1);
        chk("f2_req_off", 8'(mem_req), 8'd0);
        mem_ack = 1'b0; exec_done = 1'b1;
        tick();
        chk("f2_exec", 8'(state), 8'd3);
        chk("f2_ir_once", 8'(ir_load), 8'd0);
        tick();
        exec_done = 1'b0;
        chk("f2_upd", 8'(state), 8'd4);
        chk("f2_inc", 8'(pc_inc), 8'd1);
        chk("f2_load", 8'(pc_load), 8'd0);
        chk("f2_tgt", 8'(pc_target), 8'h0);
        tick();
        chk("f2_refetch", 8'(state), 8'd1);
        chk("f2_inc_off", 8'(pc_inc), 8'd0);
        chk("f2_addr4", 8'(mem_addr), 8'h4);

        // taken branch to A
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0; exec_done = 1'b1; branch_taken = 1'b1; branch_target = 4'hA;
        tick();
        tick();
        exec_done = 1'b0; branch_taken = 1'b0; branch_target = 4'h0;
        chk("br_load", 8'(pc_load), 8'd1);
        chk("br_inc", 8'(pc_inc), 8'd0);
        chk("br_tgt", 8'(pc_target), 8'hA);
        tick();
        chk("br_addr", 8'(mem_addr), 8'hA);

        // ack delayed by 5 cycles: request held 6 cycles
        for (int i = 0; i < 5; i++) begin
            chk("wt_req", 8'(mem_req), 8'd1);
            chk("wt_addr", 8'(mem_addr), 8'hA);
            tick();
        end
        chk("wt_req6", 8'(mem_req), 8'd1);
        chk("wt_addr6", 8'(mem_addr), 8'hA);
        mem_ack = 1'b1;
        tick();
        chk("wt_latch", 8'(state), 8'd2);
        mem_ack = 1'b0; exec_done = 1'b1;
        tick(); tick();
        exec_done = 1'b0;
        tick();
        chk("to_addr", 8'(mem_addr), 8'hB);

        // no ack: ERROR after 15 FETCH cycles
        for (int i = 0; i < 14; i++) tick();
        chk("to_pre", 8'(state), 8'd1);
        tick();
        chk("to_state", 8'(state), 8'd6);
        chk("to_err", 8'(err), 8'd1);
        chk("to_req", 8'(mem_req), 8'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("to_sticky", 8'(state), 8'd6);
        rst = 1'b1;
        #1;
        chk("to_rst_state", 8'(state), 8'd0);
        chk("to_rst_err", 8'(err), 8'd0);
        tick();
        rst = 1'b0;

        // halt request during EXEC
        start = 1'b1;
        tick();
        chk("h_addr", 8'(mem_addr), 8'hB);
        start = 1'b0; mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        tick();
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        chk("h_in_exec", 8'(state), 8'd3);
        exec_done = 1'b1;
        tick();
        exec_done = 1'b0;
        chk("h_upd_inc", 8'(pc_inc), 8'd1);
        tick();
        chk("h_state", 8'(state), 8'd5);
        chk("h_halted", 8'(halted), 8'd1);
        chk("h_req", 8'(mem_req), 8'd0);
        tick();
        chk("h_stay", 8'(halted), 8'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("h_resume", 8'(state), 8'd1);
        chk("h_raddr", 8'(mem_addr), 8'hC);
        chk("h_unhalt", 8'(halted), 8'd0);

        // async reset mid-fetch
        rst = 1'b1;
        #1;
        chk("r_mid_req", 8'(mem_req), 8'd0);
        chk("r_mid_state", 8'(state), 8'd0);
        tick();
        rst = 1'b0;
        tick(); tick();
        chk("r_idle", 8'(state), 8'd0);

        // wrap F -> 0 and ack on the timeout cycle
        set_req = 1'b1; set_val = 4'hF;
        tick();
        set_req = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("w_addr", 8'(mem_addr), 8'hF);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0; exec_done = 1'b1;
        tick(); tick();
        exec_done = 1'b0;
        chk("w_inc", 8'(pc_inc), 8'd1);
        tick();
        chk("w_addr0", 8'(mem_addr), 8'h0);
        for (int i = 0; i < 14; i++) tick();
        chk("w_pre", 8'(state), 8'd1);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("w_latch", 8'(state), 8'd2);
        chk("w_noerr", 8'(err), 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
